conv_event_scheduler: RTL and testbench



---
 rtl/snn_interfaces_pkg.sv | 37 +++
 rtl/conv_event_scheduler_bounds.sv | 52 +++++
 rtl/conv_event_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_conv_event_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_interfaces_pkg.sv
// Shared types for the event-driven SNN convolution blocks: coordinate
// vectors, convolution update records, scheduler states and packing helpers.
package snn_interfaces_pkg;

  localparam int VEC_COORD_BITS      = 8;
  localparam int DEFAULT_KERNEL_SIZE = 3;
  localparam int CONV_KIDX_BITS      = $clog2(DEFAULT_KERNEL_SIZE * DEFAULT_KERNEL_SIZE);

  typedef struct packed {
    logic [VEC_COORD_BITS-1:0] x;
    logic [VEC_COORD_BITS-1:0] y;
  } vec2_t;

  typedef struct packed {
    vec2_t                     coord;
    logic [CONV_KIDX_BITS-1:0] kidx;
  } conv_update_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    TS_WAIT = 2'd2
  } sched_state_e;

  // Packed bus layout is {x, y} with x in the upper half.
  function automatic vec2_t unpack_coordinates(input logic [2*VEC_COORD_BITS-1:0] bus);
    vec2_t c;
    c.x = bus[2*VEC_COORD_BITS-1:VEC_COORD_BITS];
    c.y = bus[VEC_COORD_BITS-1:0];
    return c;
  endfunction

  function automatic logic [2*VEC_COORD_BITS-1:0] pack_coordinates(input vec2_t c);
    return {c.x, c.y};
  endfunction

endpackage

// File: rtl/conv_event_scheduler_bounds.sv
// Combinational kernel-window clipping: given an event position, gives the
// range of kernel offsets whose output neuron lands inside the image, plus
// a flag telling whether the event itself lies inside the image.
module conv_window_bounds #(
  parameter int COORD_BITS  = 8,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int KB          = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1
) (
  input  logic [COORD_BITS-1:0] x_i,
  input  logic [COORD_BITS-1:0] y_i,
  output logic [KB-1:0]         kx_min_o,
  output logic [KB-1:0]         kx_max_o,
  output logic [KB-1:0]         ky_min_o,
  output logic [KB-1:0]         ky_max_o,
  output logic                  in_range_o
);

  localparam int SW = COORD_BITS + 2;
  localparam int R  = KERNEL_SIZE / 2;

  typedef logic signed [SW-1:0] sval_t;

  // Lowest kernel offset: max(0, R - c), computed two bits wider so it never wraps.
  function automatic logic [KB-1:0] clamp_lo(input logic [COORD_BITS-1:0] c);
    sval_t v;
    v = sval_t'(R) - sval_t'({2'b00, c});
    if (v < sval_t'(0)) v = sval_t'(0);
    else                v = v;
    return v[KB-1:0];
  endfunction

  // Highest kernel offset: min(K-1, lim-1-c+R).
  function automatic logic [KB-1:0] clamp_hi(input logic [COORD_BITS-1:0] c, input int lim);
    sval_t v;
    v = sval_t'(lim - 1 + R) - sval_t'({2'b00, c});
    if (v > sval_t'(KERNEL_SIZE - 1)) v = sval_t'(KERNEL_SIZE - 1);
    else                              v = v;
    return v[KB-1:0];
  endfunction

  // Window bounds and event range check, purely from the event position.
  always_comb begin
    kx_min_o   = clamp_lo(x_i);
    kx_max_o   = clamp_hi(x_i, IMG_WIDTH);
    ky_min_o   = clamp_lo(y_i);
    ky_max_o   = clamp_hi(y_i, IMG_HEIGHT);
    in_range_o = ({2'b00, x_i} < SW'(IMG_WIDTH)) && ({2'b00, y_i} < SW'(IMG_HEIGHT));
  end

endmodule

// File: rtl/conv_event_scheduler.sv
// Event scheduler for the convolution datapath: walks the clipped kernel
// window of each accepted spike, one update per handshake, and interleaves
// timestep sweeps so they never overlap a scan.
module conv_event_scheduler
  import snn_interfaces_pkg::*;
#(
  parameter int COORD_BITS  = VEC_COORD_BITS,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int KIDX_BITS   = $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    event_valid,
  output logic                    event_ready,
  input  logic [2*COORD_BITS-1:0] event_coords,
  output logic                    upd_valid,
  input  logic                    upd_ready,
  output logic [2*COORD_BITS-1:0] upd_coords,
  output logic [KIDX_BITS-1:0]    upd_kidx,
  output logic                    upd_last,
  input  logic                    ts_req,
  output logic                    ts_start,
  input  logic                    ts_done,
  output logic                    ts_ack,
  output logic                    busy,
  output logic [15:0]             drop_cnt
);

  localparam int R  = KERNEL_SIZE / 2;
  localparam int KB = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  sched_state_e   state_q, state_d;
  vec2_t          ev_q, ev_d, ev_in_s;
  logic [KB-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [KB-1:0]  kx_min_q, kx_min_d, kx_max_q, kx_max_d;
  logic [KB-1:0]  ky_min_q, ky_min_d, ky_max_q, ky_max_d;
  logic [KB-1:0]  b_kx_min_s, b_kx_max_s, b_ky_min_s, b_ky_max_s;
  logic           b_in_range_s;
  conv_update_t   upd_q, upd_d;
  logic           upd_valid_q, upd_valid_d, upd_last_q, upd_last_d;
  logic           ts_start_q, ts_start_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           ready_s, ack_s, load_s;

  assign ev_in_s = unpack_coordinates(event_coords);

  conv_window_bounds #(
    .COORD_BITS (COORD_BITS),
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT),
    .KERNEL_SIZE(KERNEL_SIZE),
    .KB         (KB)
  ) u_bounds (
    .x_i       (ev_in_s.x),
    .y_i       (ev_in_s.y),
    .kx_min_o  (b_kx_min_s),
    .kx_max_o  (b_kx_max_s),
    .ky_min_o  (b_ky_min_s),
    .ky_max_o  (b_ky_max_s),
    .in_range_o(b_in_range_s)
  );

  // Next-state logic: event intake, window walk and sweep handshake; the
  // update payload is only recomputed when a new position is loaded so it
  // stays frozen while the datapath stalls.
  always_comb begin
    state_d     = state_q;
    ev_d        = ev_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    kx_min_d    = kx_min_q;
    kx_max_d    = kx_max_q;
    ky_min_d    = ky_min_q;
    ky_max_d    = ky_max_q;
    upd_d       = upd_q;
    upd_valid_d = upd_valid_q;
    upd_last_d  = upd_last_q;
    ts_start_d  = 1'b0;
    drop_cnt_d  = drop_cnt_q;
    ready_s     = 1'b0;
    ack_s       = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        ready_s = !ts_req;
        if (ts_req) begin
          state_d    = TS_WAIT;
          ts_start_d = 1'b1;
        end else if (event_valid) begin
          if (!b_in_range_s) begin
            drop_cnt_d = (drop_cnt_q == 16'hFFFF) ? drop_cnt_q : drop_cnt_q + 16'd1;
          end else begin
            ev_d        = ev_in_s;
            kx_min_d    = b_kx_min_s;
            kx_max_d    = b_kx_max_s;
            ky_min_d    = b_ky_min_s;
            ky_max_d    = b_ky_max_s;
            kx_d        = b_kx_min_s;
            ky_d        = b_ky_min_s;
            upd_valid_d = 1'b1;
            load_s      = 1'b1;
            state_d     = SCAN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (upd_ready) begin
          if (upd_last_q) begin
            upd_valid_d = 1'b0;
            state_d     = IDLE;
          end else if (kx_q == kx_max_q) begin
            kx_d   = kx_min_q;
            ky_d   = ky_q + KB'(1);
            load_s = 1'b1;
          end else begin
            kx_d   = kx_q + KB'(1);
            load_s = 1'b1;
          end
        end else begin
          state_d = SCAN;
        end
      end
      TS_WAIT: begin
        if (ts_done) begin
          ack_s   = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = TS_WAIT;
        end
      end
      default: begin
        state_d     = IDLE;
        upd_valid_d = 1'b0;
      end
    endcase
    if (load_s) begin
      upd_d.coord.x = ev_d.x + COORD_BITS'(kx_d) - COORD_BITS'(R);
      upd_d.coord.y = ev_d.y + COORD_BITS'(ky_d) - COORD_BITS'(R);
      upd_d.kidx    = KIDX_BITS'(ky_d) * KIDX_BITS'(KERNEL_SIZE) + KIDX_BITS'(kx_d);
      upd_last_d    = (kx_d == kx_max_d) && (ky_d == ky_max_d);
    end else begin
      upd_d      = upd_q;
      upd_last_d = upd_last_q;
    end
  end

  // State and output registers with synchronous reset abandoning any scan or sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ev_q        <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      kx_min_q    <= '0;
      kx_max_q    <= '0;
      ky_min_q    <= '0;
      ky_max_q    <= '0;
      upd_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_last_q  <= 1'b0;
      ts_start_q  <= 1'b0;
      drop_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      ev_q        <= ev_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      kx_min_q    <= kx_min_d;
      kx_max_q    <= kx_max_d;
      ky_min_q    <= ky_min_d;
      ky_max_q    <= ky_max_d;
      upd_q       <= upd_d;
      upd_valid_q <= upd_valid_d;
      upd_last_q  <= upd_last_d;
      ts_start_q  <= ts_start_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign event_ready = ready_s & ~rst;
  assign ts_ack      = ack_s & ~rst;
  assign ts_start    = ts_start_q;
  assign busy        = (state_q != IDLE);
  assign upd_valid   = upd_valid_q;
  assign upd_coords  = pack_coordinates(upd_q.coord);
  assign upd_kidx    = upd_q.kidx;
  assign upd_last    = upd_last_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_conv_event_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for conv_event_scheduler: a reference model enumerates the
// clipped kernel neighbourhood of every accepted event; a monitor pops and
// compares on each update handshake.
module tb_conv_event_scheduler;

  localparam int W = 32;
  localparam int H = 32;
  localparam int K = 3;
  localparam int R = K / 2;

  typedef struct {
    int ox;
    int oy;
    int kidx;
    bit last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        event_valid = 1'b0;
  logic        event_ready;
  logic [15:0] event_coords = 16'd0;
  logic        upd_valid;
  logic        upd_ready = 1'b0;
  logic [15:0] upd_coords;
  logic [3:0]  upd_kidx;
  logic        upd_last;
  logic        ts_req = 1'b0;
  logic        ts_start;
  logic        ts_done = 1'b0;
  logic        ts_ack;
  logic        busy;
  logic [15:0] drop_cnt;

  logic [1:0]  ready_mode = 2'd1;
  exp_t        sb[$];
  int          total_cnt = 0;
  int          pass_cnt = 0;
  int          exp_drop = 0;

  conv_event_scheduler dut (
    .clk(clk), .rst(rst),
    .event_valid(event_valid), .event_ready(event_ready), .event_coords(event_coords),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_coords(upd_coords),
    .upd_kidx(upd_kidx), .upd_last(upd_last),
    .ts_req(ts_req), .ts_start(ts_start), .ts_done(ts_done), .ts_ack(ts_ack),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // upd_ready driver: forced low, forced high or random per cycle.
  always @(posedge clk) begin
    #2;
    if (ready_mode == 2'd2) upd_ready = 1'($urandom_range(0, 1));
    else                    upd_ready = ready_mode[0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: every kernel offset whose output neuron lies in the map.
  task automatic model_event(input int x, input int y);
    exp_t tmp[$];
    exp_t e;
    if (x >= W || y >= H) begin
      if (exp_drop < 65535) exp_drop++;
      return;
    end
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K; kx++) begin
        e.ox = x + kx - R;
        e.oy = y + ky - R;
        e.kidx = ky * K + kx;
        e.last = 1'b0;
        if (e.ox >= 0 && e.ox < W && e.oy >= 0 && e.oy < H) tmp.push_back(e);
      end
    end
    tmp[tmp.size() - 1].last = 1'b1;
    foreach (tmp[i]) sb.push_back(tmp[i]);
  endtask

  // Waits (bounded) for the offered event to be taken, then updates the model.
  task automatic accept_wait(input int x, input int y);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (event_ready) begin
        model_event(x, y);
        @(posedge clk);
        #1 event_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    event_valid = 1'b0;
  endtask

  task automatic send_event(input int x, input int y);
    event_valid  = 1'b1;
    event_coords = {8'(x), 8'(y)};
    accept_wait(x, y);
  endtask

  // Monitor: payload stability while stalled, scoreboard compare on handshake.
  logic        stalled = 1'b0;
  logic [20:0] stall_val = 21'd0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {11'd0, upd_valid, upd_coords, upd_kidx, upd_last},
                         {11'd0, 1'b1, stall_val});
      if (upd_valid && !upd_ready) begin
        stalled   = 1'b1;
        stall_val = {upd_coords, upd_kidx, upd_last};
      end else begin
        stalled = 1'b0;
      end
      if (upd_valid && upd_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_update", {11'd0, upd_coords, upd_kidx, upd_last}, 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("update", {11'd0, upd_coords, upd_kidx, upd_last},
                {11'd0, 8'(e.ox), 8'(e.oy), 4'(e.kidx), e.last});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bit prev_busy;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {event_ready, upd_valid, upd_last, ts_start, ts_ack, busy},
          {26'd0, 6'd0});
    check("rst_payload", {12'd0, upd_coords, upd_kidx}, 32'd0);
    check("rst_drop", {16'd0, drop_cnt}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: centre event, full window, latency and re-ready timing
    send_event(10, 10);
    @(negedge clk);
    check("first_valid_latency", {31'd0, upd_valid}, 32'd1);
    repeat (8) @(negedge clk);
    @(negedge clk);
    check("ready_after_scan", {30'd0, event_ready, upd_valid}, 32'd2);

    // 2: corner events
    @(posedge clk); #1;
    send_event(0, 0);
    send_event(31, 31);
    repeat (8) @(posedge clk);

    // 3: stall on the 4th update
    #1 send_event(10, 10);
    repeat (3) @(posedge clk);
    #1 ready_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_payload", {11'd0, upd_valid, upd_coords, upd_kidx},
            {11'd0, 1'b1, 8'd9, 8'd10, 4'd3});
    end
    @(posedge clk);
    #1 ready_mode = 2'd1;
    repeat (10) @(posedge clk);
    check("stall_all_done", sb.size(), 32'd0);

    // 3b: reset mid-scan
    #1 send_event(10, 10);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    ready_mode = 2'd0;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    exp_drop = 0;
    @(negedge clk);
    check("mid_scan_reset", {13'd0, upd_valid, busy, event_ready, drop_cnt}, {13'd0, 3'b001, 16'd0});
    @(posedge clk);
    #1 ready_mode = 2'd1;

    // 4: out-of-range events
    send_event(40, 5);
    send_event(5, 32);
    @(negedge clk);
    check("drop_count", {16'd0, drop_cnt}, exp_drop);
    check("drop_ready", {30'd0, event_ready, upd_valid}, 32'd2);

    // 4b: saturation
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    event_valid  = 1'b1;
    event_coords = {8'd40, 8'd40};
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("drop_below_sat", {16'd0, drop_cnt}, 32'h0000FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("drop_saturated", {16'd0, drop_cnt}, 32'h0000FFFF);
    @(posedge clk);
    #1 event_valid = 1'b0;
    exp_drop = 65535;

    // 5: ts_req wins over simultaneous event
    ts_req       = 1'b1;
    event_valid  = 1'b1;
    event_coords = {8'd10, 8'd10};
    @(negedge clk);
    check("ts_priority_ready", {31'd0, event_ready}, 32'd0);
    @(negedge clk);
    check("ts_start_pulse", {30'd0, ts_start, busy}, 32'd3);
    @(negedge clk);
    check("ts_start_single", {30'd0, ts_start, ts_ack}, 32'd0);
    repeat (3) @(posedge clk);
    #1 ts_done = 1'b1;
    @(negedge clk);
    check("ts_ack_pulse", {31'd0, ts_ack}, 32'd1);
    @(posedge clk);
    #1 ts_done = 1'b0;
    ts_req = 1'b0;
    accept_wait(10, 10);
    repeat (12) @(posedge clk);

    // 6: ts_req raised mid-scan waits for the scan
    #1 send_event(10, 10);
    repeat (3) @(posedge clk);
    #1 ts_req = 1'b1;
    seen = 1'b0;
    prev_busy = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (ts_start) begin
        seen = 1'b1;
        check("ts_after_scan", sb.size(), 32'd0);
        check("ts_start_timing", {31'd0, prev_busy}, 32'd0);
      end
      prev_busy = busy;
    end
    check("ts_start_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1 ts_done = 1'b1;
    @(negedge clk);
    check("ts_ack_mid", {31'd0, ts_ack}, 32'd1);
    @(posedge clk);
    #1 ts_done = 1'b0;
    ts_req = 1'b0;

    // Random traffic with random back-pressure
    ready_mode = 2'd2;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1 send_event($urandom_range(0, 35), $urandom_range(0, 35));
    end
    for (int i = 0; i < 500 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("drain", sb.size(), 32'd0);
    check("final_drop", {16'd0, drop_cnt}, exp_drop);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
